// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage registers: occupancy
// encoding, the NOP instruction, and the payload layout of every stage.
package pipe_pkg;

    // The skid state is encoded directly as the number of entries held.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

    // addi x0, x0, 0 -- loaded into the instruction field on reset.
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;

    // IF/ID payload: pc, instruction.
    localparam int IF_ID_PC_OFF    = 0;
    localparam int IF_ID_INSTR_OFF = IF_ID_PC_OFF + XLEN;
    localparam int IF_ID_W         = IF_ID_INSTR_OFF + XLEN;

    // ID/EX payload: pc, instruction, control bits, rs1 data, rs2 data.
    localparam int ID_EX_PC_OFF    = 0;
    localparam int ID_EX_INSTR_OFF = ID_EX_PC_OFF + XLEN;
    localparam int ID_EX_CTRL_OFF  = ID_EX_INSTR_OFF + XLEN;
    localparam int ID_EX_RS1_OFF   = ID_EX_CTRL_OFF + CTRL_W;
    localparam int ID_EX_RS2_OFF   = ID_EX_RS1_OFF + XLEN;
    localparam int ID_EX_W         = ID_EX_RS2_OFF + XLEN;

    // EX/MEM payload: pc, instruction, control bits, ALU result, store data.
    localparam int EX_MEM_PC_OFF    = 0;
    localparam int EX_MEM_INSTR_OFF = EX_MEM_PC_OFF + XLEN;
    localparam int EX_MEM_CTRL_OFF  = EX_MEM_INSTR_OFF + XLEN;
    localparam int EX_MEM_ALU_OFF   = EX_MEM_CTRL_OFF + CTRL_W;
    localparam int EX_MEM_RS2_OFF   = EX_MEM_ALU_OFF + XLEN;
    localparam int EX_MEM_W         = EX_MEM_RS2_OFF + XLEN;

    // MEM/WB payload: pc, instruction, control bits, writeback result.
    localparam int MEM_WB_PC_OFF     = 0;
    localparam int MEM_WB_INSTR_OFF  = MEM_WB_PC_OFF + XLEN;
    localparam int MEM_WB_CTRL_OFF   = MEM_WB_INSTR_OFF + XLEN;
    localparam int MEM_WB_RESULT_OFF = MEM_WB_CTRL_OFF + CTRL_W;
    localparam int MEM_WB_W          = MEM_WB_RESULT_OFF + XLEN;

    // True when a stage in the given state still has room for another beat.
    function automatic logic occ_has_room(input occ_state_e s);
        return (s != OCC_TWO);
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit payload register with load enable; reset loads RESET_PAYLOAD.
module pipe_data_reg #(
    parameter int                 WIDTH         = 32,
    parameter logic [WIDTH-1:0]   RESET_PAYLOAD = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Reset wins over a load; otherwise capture the payload when enabled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_q <= RESET_PAYLOAD;
        end else if (i_load) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage register with valid/ready handshake and flush.
// SKID=0: one slot, ready passes straight through from downstream.
// SKID=1: two slots, ready comes from a flop so the stall chain is cut here.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int               WIDTH         = 32,
    parameter int               SKID          = 1,
    parameter logic [WIDTH-1:0] RESET_PAYLOAD = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_occupancy
);

    logic             in_xfer;
    logic             out_xfer;
    logic             head_load;
    logic [WIDTH-1:0] head_d;

    assign in_xfer  = i_valid & o_ready;
    assign out_xfer = o_valid & i_ready;

    // The head register drives o_data directly with no output mux.
    pipe_data_reg #(
        .WIDTH         (WIDTH),
        .RESET_PAYLOAD (RESET_PAYLOAD)
    ) u_head (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (head_load),
        .i_d    (head_d),
        .o_q    (o_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            occ_state_e       state_q;
            occ_state_e       state_d;
            logic             ready_q;
            logic             skid_load;
            logic             head_from_skid;
            logic [WIDTH-1:0] skid_q;

            pipe_data_reg #(
                .WIDTH         (WIDTH),
                .RESET_PAYLOAD (RESET_PAYLOAD)
            ) u_skid (
                .i_clk  (i_clk),
                .i_rst  (i_rst),
                .i_load (skid_load),
                .i_d    (i_data),
                .o_q    (skid_q)
            );

            // State register plus a registered ready that looks one state ahead.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    state_q <= OCC_EMPTY;
                    ready_q <= 1'b1;
                end else begin
                    state_q <= state_d;
                    ready_q <= occ_has_room(state_d);
                end
            end

            // Next occupancy and the payload moves into head/skid for this cycle.
            always_comb begin
                state_d        = state_q;
                head_load      = 1'b0;
                skid_load      = 1'b0;
                head_from_skid = 1'b0;
                if (i_flush) begin
                    state_d = OCC_EMPTY;
                end else begin
                    case (state_q)
                        OCC_EMPTY: begin
                            if (in_xfer) begin
                                head_load = 1'b1;
                                state_d   = OCC_ONE;
                            end
                        end
                        OCC_ONE: begin
                            if (in_xfer && out_xfer) begin
                                head_load = 1'b1;
                            end else if (in_xfer) begin
                                skid_load = 1'b1;
                                state_d   = OCC_TWO;
                            end else if (out_xfer) begin
                                state_d = OCC_EMPTY;
                            end
                        end
                        OCC_TWO: begin
                            if (out_xfer) begin
                                head_load      = 1'b1;
                                head_from_skid = 1'b1;
                                state_d        = OCC_ONE;
                            end
                        end
                        default: begin
                            state_d = OCC_EMPTY;
                        end
                    endcase
                end
            end

            assign head_d      = head_from_skid ? skid_q : i_data;
            assign o_valid     = (state_q != OCC_EMPTY);
            assign o_ready     = ready_q;
            assign o_occupancy = state_q;
        end else begin : g_single
            logic valid_q;

            // Single slot: fill on accept, empty on drain, squash on flush.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    valid_q <= 1'b0;
                end else if (i_flush) begin
                    valid_q <= 1'b0;
                end else if (in_xfer) begin
                    valid_q <= 1'b1;
                end else if (out_xfer) begin
                    valid_q <= 1'b0;
                end
            end

            assign head_load   = in_xfer & ~i_flush;
            assign head_d      = i_data;
            assign o_valid     = valid_q;
            assign o_ready     = ~valid_q | i_ready;
            assign o_occupancy = {1'b0, valid_q};
        end
    endgenerate

    a_data_stable: assert property (@(posedge i_clk) disable iff (i_rst)
        (o_valid && !i_ready && !i_flush) |=> $stable(o_data));

    a_occ_max: assert property (@(posedge i_clk) disable iff (i_rst)
        (o_occupancy <= 2'd2));

    a_occ_single: assert property (@(posedge i_clk) disable iff (i_rst)
        (SKID == 0) |-> (o_occupancy <= 2'd1));

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a SKID=1 and a SKID=0 instance share one
// input stream and are each compared with a queue-based model of the stage.
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    localparam int W = 32;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_flush;
    logic         i_valid;
    logic         i_ready;
    logic [W-1:0] i_data;

    logic         s1_ready, s1_valid;
    logic [W-1:0] s1_data;
    logic [1:0]   s1_occ;
    logic         s0_ready, s0_valid;
    logic [W-1:0] s0_data;
    logic [1:0]   s0_occ;

    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];
    bit           clean1, clean0;
    bit           checks_on;
    int           n_checks;
    int           n_pass;

    always #5 i_clk = ~i_clk;

    pipe_stage_elastic #(.WIDTH(W), .SKID(1), .RESET_PAYLOAD(NOP_INSTR)) dut_skid (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .o_ready     (s1_ready),
        .i_data      (i_data),
        .o_valid     (s1_valid),
        .i_ready     (i_ready),
        .o_data      (s1_data),
        .o_occupancy (s1_occ)
    );

    pipe_stage_elastic #(.WIDTH(W), .SKID(0), .RESET_PAYLOAD(NOP_INSTR)) dut_single (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .o_ready     (s0_ready),
        .i_data      (i_data),
        .o_valid     (s0_valid),
        .i_ready     (i_ready),
        .o_data      (s0_data),
        .o_occupancy (s0_occ)
    );

    // Count one comparison and report it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle, compare both stages against the model, then advance the model.
    task automatic applyStimulus(input logic rst, input logic flush, input logic valid,
                                 input logic [W-1:0] data, input logic ready);
        bit in1, out1, in0, out0;
        @(negedge i_clk);
        i_rst   = rst;
        i_flush = flush;
        i_valid = valid;
        i_data  = data;
        i_ready = ready;
        #1;
        if (checks_on) begin
            checkOutput("skid_valid", 32'(s1_valid), 32'(q1.size() > 0));
            checkOutput("skid_ready", 32'(s1_ready), 32'(q1.size() < 2));
            checkOutput("skid_occ",   32'(s1_occ),   32'(q1.size()));
            if (q1.size() > 0)
                checkOutput("skid_data", s1_data, q1[0]);
            else if (clean1)
                checkOutput("skid_rst_data", s1_data, NOP_INSTR);
            checkOutput("single_valid", 32'(s0_valid), 32'(q0.size() > 0));
            checkOutput("single_ready", 32'(s0_ready), 32'((q0.size() == 0) || ready));
            checkOutput("single_occ",   32'(s0_occ),   32'(q0.size()));
            if (q0.size() > 0)
                checkOutput("single_data", s0_data, q0[0]);
            else if (clean0)
                checkOutput("single_rst_data", s0_data, NOP_INSTR);
        end
        in1  = valid && (q1.size() < 2);
        out1 = (q1.size() > 0) && ready;
        in0  = valid && ((q0.size() == 0) || ready);
        out0 = (q0.size() > 0) && ready;
        @(posedge i_clk);
        if (rst) begin
            q1.delete();
            q0.delete();
            clean1    = 1'b1;
            clean0    = 1'b1;
            checks_on = 1'b1;
        end else if (flush) begin
            q1.delete();
            q0.delete();
            clean1 = 1'b0;
            clean0 = 1'b0;
        end else begin
            if (out1) void'(q1.pop_front());
            if (in1) begin
                q1.push_back(data);
                clean1 = 1'b0;
            end
            if (out0) void'(q0.pop_front());
            if (in0) begin
                q0.push_back(data);
                clean0 = 1'b0;
            end
        end
    endtask

    // Directed scenarios first, then a randomized stretch, then the summary.
    initial begin
        n_checks  = 0;
        n_pass    = 0;
        checks_on = 1'b0;
        clean1    = 1'b0;
        clean0    = 1'b0;
        i_rst     = 1'b1;
        i_flush   = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        i_data    = '0;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);

        $display("[TB] streaming");
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, W'(i), 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);

        $display("[TB] backpressure");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hA, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);

        $display("[TB] flush");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h5, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h6, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h7, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h8, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);

        $display("[TB] single-slot ready follows downstream");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, W'(32'h90 + i), 1'(i % 2));
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, W'(32'hA0 + i), 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);

        $display("[TB] reset while full");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h12, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h13, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 99) == 0),
                          1'($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 3) != 0),
                          W'($urandom),
                          1'($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Generic, parametrised replacement for the hand-written inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque WIDTH-bit payload between two pipeline stages with a valid/ready handshake, synchronous flush, and programmable reset payload.
- Optional 2-entry skid mode (SKID=1) registers the upstream ready path to break long stall-combinational chains. SKID=0 is a single-slot register with pass-through ready.
- The core top-level packs per-stage fields (pc, instruction, control bits, forwarded rs1/rs2 data) into the payload and unpacks them on the far side.

Parameters:
- WIDTH, 32, payload width in bits (1..1024).
- SKID, 1, 0 = single slot with combinational o_ready; 1 = two slots with registered o_ready.
- RESET_PAYLOAD, {WIDTH{1'b0}}, value loaded into every payload register on reset. Stage instantiations place the NOP encoding 32'h00000013 in the instruction field.

Ports:
- i_clk  in  1  clock, all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous squash of all held entries (branch mispredict / trap).
- i_valid  in  1  upstream payload valid.
- o_ready  out  1  stage can accept a payload this cycle.
- i_data  in  WIDTH  upstream payload.
- o_valid  out  1  downstream payload valid.
- i_ready  in  1  downstream accepts this cycle.
- o_data  out  WIDTH  downstream payload, driven directly from the head register.
- o_occupancy  out  2  number of valid entries held (0..2; max 1 when SKID=0).

Behaviour:
- Transfers:
  - An input transfer occurs when i_valid & o_ready.
  - An output transfer occurs when o_valid & i_ready.
  - Payloads are delivered in order, bit-exact, with no duplication and no loss.
- Reset (i_rst=1 at a clock edge):
  - o_valid=0, o_occupancy=0, both payload registers = RESET_PAYLOAD, o_data=RESET_PAYLOAD.
  - o_ready=1 from the first cycle after reset.
  - Reset overrides flush and any in-flight transfer, including reset asserted mid-stall with 2 entries held.
- Flush (i_flush=1, i_rst=0):
  - Next cycle: o_valid=0, occupancy=0.
  - A coincident input transfer is discarded (flush wins).
  - Payload registers hold their values; they are not reloaded with RESET_PAYLOAD.
  - Downstream must not sample o_data while o_valid=0.
- SKID=0:
  - o_ready = ~o_valid | i_ready (combinational).
  - Head register loads i_data on an input transfer; otherwise o_valid clears on an output transfer.
  - Latency 1 cycle.
  - Sustains 1 transfer per cycle under continuous i_ready=1.
- SKID=1 state machine, encoded as occupancy:
  - EMPTY (0): o_valid=0, o_ready=1. On input: load head, go ONE.
  - ONE (1): o_valid=1, o_ready=1.
    - Input only: load skid, go TWO.
    - Output only: go EMPTY.
    - Input and output together: load head, stay ONE.
  - TWO (2): o_valid=1, o_ready=0.
    - Output: head <= skid, go ONE.
    - No output: hold.
  - o_ready is a flop output: high exactly when next-state occupancy < 2. It has no combinational path from i_ready.
  - Latency 1 cycle, EMPTY to o_valid.
  - Full throughput while i_ready=1.
  - A single i_ready=0 cycle absorbs one extra beat with no upstream bubble.
- Occupancy is never observed above 2.
- Input while o_ready=0 is ignored; upstream holds i_data/i_valid by protocol.
- Assertions (simulation only):
  - o_valid & ~i_ready implies o_data stable next cycle unless i_flush or i_rst.
  - o_occupancy <= 1 when SKID=0.

Decomposition:
- Shared package pipe_pkg:
  - Occupancy constants OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_TWO=2'd2.
  - Constant NOP_INSTR=32'h00000013.
  - Per-stage payload field widths/offsets (MEM_WB_W, etc.) used by instantiations.
- One sub-module, pipe_data_reg: WIDTH-bit register with load enable and RESET_PAYLOAD on synchronous reset. It is instantiated as head and, when SKID=1, as skid.
- The skid slot and its state logic are generated out when SKID=0.

Test Plan:
- Reset: WIDTH=32, RESET_PAYLOAD=32'h00000013, assert i_rst 2 cycles -> o_valid=0, o_data=32'h00000013, o_occupancy=0, o_ready=1 on the first cycle after release.
- Streaming: SKID=1, i_ready=1, inputs 1,2,3,4 on consecutive cycles -> o_data 1,2,3,4 with o_valid, each one cycle after its input, o_ready never low.
- Backpressure: SKID=1, send A,B,C; i_ready=0 from cycle of A's output -> o_occupancy reaches 2, o_ready=0, C held upstream; raise i_ready -> A,B,C delivered in order, no duplicates.
- Flush: occupancy 2 holding 5,6; assert i_flush with i_valid=1, data 7 -> next cycle o_valid=0, occupancy 0; 7 never emerges; next input 8 appears after 1 cycle.
- SKID=0 combinational ready: o_valid=1, i_ready toggles 0/1 -> o_ready mirrors i_ready in the same cycle; throughput 1 per cycle when i_ready=1.
- Reset mid-operation: occupancy 2, i_rst=1 together with i_flush=1 and i_valid=1 -> next cycle o_valid=0, o_data=RESET_PAYLOAD, occupancy 0.
